// File: rtl/stream_pkg.sv
// Shared definitions for the stream width-conversion blocks.
// Holds the default word width and the lane-index width helper.
package stream_pkg;

    localparam int DEFAULT_WORD_WIDTH = 32;

    // Width of a lane counter covering 0..ratio-1; never narrower than 1 bit.
    function automatic int lane_count_width(input int ratio);
        return (ratio <= 2) ? 1 : $clog2(ratio);
    endfunction

endpackage : stream_pkg

// File: rtl/stream_upsizer.sv
// Packs RATIO narrow input words into one wide output word, lane 0 first.
// A packet end (input_last) closes the word early with unused lanes zeroed.
module stream_upsizer
    import stream_pkg::*;
#(
    parameter int WORD_WIDTH = DEFAULT_WORD_WIDTH,
    parameter int RATIO      = 4
) (
    input  logic                        clock,
    input  logic                        rst_n,
    input  logic                        input_valid,
    output logic                        input_ready,
    input  logic [WORD_WIDTH-1:0]       input_data,
    input  logic                        input_last,
    output logic                        output_valid,
    input  logic                        output_ready,
    output logic [WORD_WIDTH*RATIO-1:0] output_data,
    output logic [RATIO-1:0]            output_keep,
    output logic                        output_last
);

    localparam int COUNT_WIDTH = lane_count_width(RATIO);

    typedef logic [COUNT_WIDTH-1:0] lane_idx_t;

    if (RATIO < 2 || WORD_WIDTH < 1) begin : g_bad_params
        $error("stream_upsizer: RATIO must be >= 2 and WORD_WIDTH >= 1");
    end

    logic                        valid_q, valid_d;
    logic                        last_q,  last_d;
    logic [RATIO-1:0]            keep_q,  keep_d;
    logic [WORD_WIDTH*RATIO-1:0] data_q,  data_d;
    lane_idx_t                   count_q, count_d;

    logic in_fire;
    logic out_fire;

    // A held word blocks input unless it leaves in the same cycle.
    assign input_ready = !valid_q || output_ready;
    assign in_fire     = input_valid && input_ready;
    assign out_fire    = valid_q && output_ready;

    // Departure clears the register first, so a simultaneous arrival lands in
    // lane 0 of a clean word (count is already 0 while a word is held).
    always_comb begin
        valid_d = valid_q;
        last_d  = last_q;
        keep_d  = keep_q;
        data_d  = data_q;
        count_d = count_q;

        if (out_fire) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            keep_d  = '0;
            data_d  = '0;
            count_d = '0;
        end

        if (in_fire) begin
            data_d[count_d*WORD_WIDTH +: WORD_WIDTH] = input_data;
            keep_d[count_d]                          = 1'b1;
            if (count_d == lane_idx_t'(RATIO - 1) || input_last) begin
                valid_d = 1'b1;
                last_d  = input_last;
                count_d = '0;
            end else begin
                count_d = count_d + lane_idx_t'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            keep_q  <= '0;
            data_q  <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            last_q  <= last_d;
            keep_q  <= keep_d;
            data_q  <= data_d;
            count_q <= count_d;
        end
    end

    assign output_valid = valid_q;
    assign output_last  = last_q;
    assign output_keep  = keep_q;
    assign output_data  = data_q;

endmodule : stream_upsizer

// File: tb/tb_stream_upsizer.sv
// Directed bench for stream_upsizer at WORD_WIDTH=8, RATIO=4: a vector table
// for the streaming cases plus hand sequences for stall and mid-word reset.
module tb_stream_upsizer;

    localparam int W = 8;
    localparam int R = 4;

    logic           clock;
    logic           rst_n;
    logic           input_valid;
    logic           input_ready;
    logic [W-1:0]   input_data;
    logic           input_last;
    logic           output_valid;
    logic           output_ready;
    logic [W*R-1:0] output_data;
    logic [R-1:0]   output_keep;
    logic           output_last;

    int checks;
    int errors;

    typedef struct {
        logic        in_valid;
        logic [7:0]  in_data;
        logic        in_last;
        logic        out_ready;
        logic        exp_in_ready;
        logic        exp_valid;
        logic [31:0] exp_data;
        logic [3:0]  exp_keep;
        logic        exp_last;
    } vec_t;

    localparam int NVEC = 21;
    vec_t vecs[NVEC];

    stream_upsizer #(.WORD_WIDTH(W), .RATIO(R)) dut (
        .clock        (clock),
        .rst_n        (rst_n),
        .input_valid  (input_valid),
        .input_ready  (input_ready),
        .input_data   (input_data),
        .input_last   (input_last),
        .output_valid (output_valid),
        .output_ready (output_ready),
        .output_data  (output_data),
        .output_keep  (output_keep),
        .output_last  (output_last)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_ready(input string name, input logic exp);
        checks++;
        if (input_ready !== exp) begin
            errors++;
            $display("[TB] FAIL %s input_ready got %b want %b", name, input_ready, exp);
        end
    endtask

    task automatic check_output(input string name, input logic ev, input logic [31:0] ed,
                                input logic [3:0] ek, input logic el);
        checks++;
        if (output_valid !== ev || output_data !== ed || output_keep !== ek || output_last !== el) begin
            errors++;
            $display("[TB] FAIL %s got valid=%b data=%h keep=%b last=%b want valid=%b data=%h keep=%b last=%b",
                     name, output_valid, output_data, output_keep, output_last, ev, ed, ek, el);
        end
    endtask

    // Drive one cycle of inputs, check ready before the edge and outputs after it.
    task automatic apply_stimulus(input string name, input logic v, input logic [7:0] d,
                                  input logic l, input logic ordy, input logic exp_rdy,
                                  input logic ev, input logic [31:0] ed,
                                  input logic [3:0] ek, input logic el);
        input_valid  = v;
        input_data   = d;
        input_last   = l;
        output_ready = ordy;
        #1;
        check_ready(name, exp_rdy);
        @(posedge clock);
        #1;
        check_output(name, ev, ed, ek, el);
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        rst_n        = 1'b0;
        input_valid  = 1'b0;
        input_data   = '0;
        input_last   = 1'b0;
        output_ready = 1'b1;

        //            v     data   l     ordy  rdy   ov    odata         keep     last
        vecs[0]  = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00000011, 4'b0001, 1'b0};
        vecs[1]  = '{1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00002211, 4'b0011, 1'b0};
        vecs[2]  = '{1'b1, 8'h33, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00332211, 4'b0111, 1'b0};
        vecs[3]  = '{1'b1, 8'h44, 1'b0, 1'b1, 1'b1, 1'b1, 32'h44332211, 4'b1111, 1'b0};
        vecs[4]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00000000, 4'b0000, 1'b0};
        vecs[5]  = '{1'b1, 8'hA1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h000000A1, 4'b0001, 1'b0};
        vecs[6]  = '{1'b1, 8'hA2, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000A2A1, 4'b0011, 1'b1};
        vecs[7]  = '{1'b1, 8'hB1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h000000B1, 4'b0001, 1'b0};
        vecs[8]  = '{1'b1, 8'hB2, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000B2B1, 4'b0011, 1'b1};
        vecs[9]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00000000, 4'b0000, 1'b0};
        vecs[10] = '{1'b1, 8'h5A, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000005A, 4'b0001, 1'b1};
        vecs[11] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00000000, 4'b0000, 1'b0};
        vecs[12] = '{1'b1, 8'h01, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00000001, 4'b0001, 1'b0};
        vecs[13] = '{1'b1, 8'h02, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00000201, 4'b0011, 1'b0};
        vecs[14] = '{1'b1, 8'h03, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00030201, 4'b0111, 1'b0};
        vecs[15] = '{1'b1, 8'h04, 1'b0, 1'b1, 1'b1, 1'b1, 32'h04030201, 4'b1111, 1'b0};
        vecs[16] = '{1'b1, 8'h05, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00000005, 4'b0001, 1'b0};
        vecs[17] = '{1'b1, 8'h06, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00000605, 4'b0011, 1'b0};
        vecs[18] = '{1'b1, 8'h07, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00070605, 4'b0111, 1'b0};
        vecs[19] = '{1'b1, 8'h08, 1'b0, 1'b1, 1'b1, 1'b1, 32'h08070605, 4'b1111, 1'b0};
        vecs[20] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00000000, 4'b0000, 1'b0};

        #12;
        check_ready("reset_ready", 1'b1);
        check_output("reset_outputs", 1'b0, 32'h0, 4'b0000, 1'b0);
        @(negedge clock);
        rst_n = 1'b1;
        @(posedge clock);
        #1;

        for (int i = 0; i < NVEC; i++) begin
            apply_stimulus($sformatf("vec%0d", i), vecs[i].in_valid, vecs[i].in_data,
                           vecs[i].in_last, vecs[i].out_ready, vecs[i].exp_in_ready,
                           vecs[i].exp_valid, vecs[i].exp_data, vecs[i].exp_keep,
                           vecs[i].exp_last);
        end

        // Backpressure: a full word waits while a new input is offered.
        apply_stimulus("stall_fill0", 1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00000011, 4'b0001, 1'b0);
        apply_stimulus("stall_fill1", 1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00002211, 4'b0011, 1'b0);
        apply_stimulus("stall_fill2", 1'b1, 8'h33, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00332211, 4'b0111, 1'b0);
        apply_stimulus("stall_fill3", 1'b1, 8'h44, 1'b0, 1'b1, 1'b1, 1'b1, 32'h44332211, 4'b1111, 1'b0);
        for (int i = 0; i < 5; i++) begin
            apply_stimulus($sformatf("stall_hold%0d", i), 1'b1, 8'h55, 1'b0, 1'b0, 1'b0,
                           1'b1, 32'h44332211, 4'b1111, 1'b0);
        end
        apply_stimulus("stall_release", 1'b1, 8'h55, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00000055, 4'b0001, 1'b0);
        apply_stimulus("stall_next1", 1'b1, 8'h66, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00006655, 4'b0011, 1'b0);
        apply_stimulus("stall_next2", 1'b1, 8'h77, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00776655, 4'b0111, 1'b0);
        apply_stimulus("stall_next3", 1'b1, 8'h88, 1'b0, 1'b1, 1'b1, 1'b1, 32'h88776655, 4'b1111, 1'b0);
        apply_stimulus("stall_drain", 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00000000, 4'b0000, 1'b0);

        // Reset in the middle of a word discards it asynchronously.
        apply_stimulus("rst_pre0", 1'b1, 8'h01, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00000001, 4'b0001, 1'b0);
        apply_stimulus("rst_pre1", 1'b1, 8'h02, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00000201, 4'b0011, 1'b0);
        input_valid = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        check_output("rst_async_clear", 1'b0, 32'h0, 4'b0000, 1'b0);
        check_ready("rst_async_ready", 1'b1);
        @(posedge clock);
        @(negedge clock);
        rst_n = 1'b1;
        @(posedge clock);
        #1;
        apply_stimulus("rst_post0", 1'b1, 8'h01, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00000001, 4'b0001, 1'b0);
        apply_stimulus("rst_post1", 1'b1, 8'h02, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00000201, 4'b0011, 1'b0);
        apply_stimulus("rst_post2", 1'b1, 8'h03, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00030201, 4'b0111, 1'b0);
        apply_stimulus("rst_post3", 1'b1, 8'h04, 1'b0, 1'b1, 1'b1, 1'b1, 32'h04030201, 4'b1111, 1'b0);
        apply_stimulus("rst_drain", 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00000000, 4'b0000, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_stream_upsizer

// File: doc/stream_upsizer.md
STREAM_UPSIZER -- requirements
Module: stream_upsizer

Interface
REQ-001 The block SHALL have parameter WORD_WIDTH, default 32, giving the input word width in bits.
REQ-002 The block SHALL have parameter RATIO, default 4, giving the number of input words packed per output word.
REQ-003 Port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port input_valid, input, 1 bit: the upstream word is valid.
REQ-006 Port input_ready, output, 1 bit: the block accepts the upstream word this cycle.
REQ-007 Port input_data, input, WORD_WIDTH bits: the upstream word.
REQ-008 Port input_last, input, 1 bit: the upstream word ends a packet.
REQ-009 Port output_valid, output, 1 bit: the packed word is valid.
REQ-010 Port output_ready, input, 1 bit: downstream accepts the packed word.
REQ-011 Port output_data, output, WORD_WIDTH*RATIO bits: the packed word.
REQ-012 Port output_keep, output, RATIO bits: one bit per lane, set when that lane holds a real input word.
REQ-013 Port output_last, output, 1 bit: the packed word ends a packet.

Function
REQ-014 A handshake SHALL occur on each side only in a cycle where valid and ready are both 1.
REQ-015 input_ready SHALL equal (!output_valid || output_ready), combinationally, with no other dependency.
REQ-016 The block SHALL hold a lane counter, range 0..RATIO-1, giving the lane the next accepted word is written to.
REQ-017 An accepted word SHALL be written into output_data lane [count*WORD_WIDTH +: WORD_WIDTH]; the first word goes to lane 0 (LSBs).
REQ-018 An accepted word SHALL set its output_keep bit.
REQ-019 The word is complete when its accepted word lands in lane RATIO-1 or carries input_last=1.
REQ-020 On the handshake of a completing word, output_valid SHALL be 1 from the next cycle (latency 1), output_last SHALL equal that word's input_last, and count SHALL go to 0.
REQ-021 While output_valid=1 and output_ready=0, output_data, output_keep and output_last SHALL hold stable, and input_ready SHALL be 0.
REQ-022 Output handshake without a simultaneous input handshake: output_valid, output_keep, output_last and output_data SHALL clear to 0 on the next cycle.
REQ-023 Output handshake with a simultaneous input handshake: the register SHALL restart with that input word in lane 0 and only keep[0] set. This gives sustained throughput of one input word per cycle.
REQ-024 Lanes not yet written SHALL read as data 0 and keep 0.
REQ-025 input_last accepted at count=0 SHALL produce a one-lane word: keep = 1, last = 1.
REQ-026 input_valid=1 with input_ready=0 SHALL leave all state unchanged.
REQ-027 RATIO < 2 or WORD_WIDTH < 1 SHALL cause an elaboration-time error.

Reset
REQ-028 While rst_n=0, output_valid, output_last, output_keep, output_data and count SHALL be 0, asynchronously.
REQ-029 Assertion of reset mid-word SHALL discard the partial word; the first handshake after release SHALL land in lane 0.
REQ-030 input_ready SHALL be 1 during and after reset, consistent with output_valid=0.

Structure
REQ-031 The shared package stream_pkg SHALL hold the lane-count width function (clog2 of RATIO) and the default WORD_WIDTH constant; the block SHALL define no typedefs locally beyond the lane index.
REQ-032 The block SHALL be a single module with no sub-module: one output/assembly register set plus the lane counter.
REQ-033 The block SHALL not add an extra buffer stage; downstream decoupling belongs to a separate buffer stage instantiated by the integrator.

Verification (WORD_WIDTH=8, RATIO=4)
REQ-034 Inputs 0x11, 0x22, 0x33, 0x44 back-to-back, output_ready=1 -> one cycle later output_data=0x44332211, keep=4'b1111, last=0.
REQ-035 Inputs 0xA1, 0xA2 with last on 0xA2 -> output_data=0x0000A2A1, keep=4'b0011, last=1; next word starts in lane 0.
REQ-036 Eight words streamed continuously, output_ready=1 -> input_ready held 1 every cycle; outputs 0x04030201 then 0x08070605 on consecutive handshakes.
REQ-037 Complete word presented with output_ready=0 for 5 cycles -> input_ready=0, output fields stable throughout; on release the word is consumed and the waiting input lands in lane 0.
REQ-038 rst_n pulsed low after two accepted words -> all outputs 0 immediately; the next four words 0x01..0x04 yield 0x04030201.
REQ-039 Single input 0x5A with last=1 at count=0 -> output_data=0x0000005A, keep=4'b0001, last=1.
